// File: rtl/data_sram_bridge.sv
// Data-memory bridge: core single-cycle port to split req/addr_ok/data_ok bus.
// Stalls the core while an access is outstanding.
module data_sram_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_en,
  input  logic [DATA_W/8-1:0] cpu_wen,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_stall,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [1:0]          bus_size,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic       wen_wr;
  logic [1:0] wen_size;
  logic       issue;

  assign issue = (state == IDLE) && cpu_en;

  always_comb begin
    wen_wr   = |cpu_wen;
    wen_size = 2'd2;
    case (cpu_wen)
      BE_W'(4'b0011),
      BE_W'(4'b1100): wen_size = 2'd1;
      BE_W'(4'b0001),
      BE_W'(4'b0010),
      BE_W'(4'b0100),
      BE_W'(4'b1000): wen_size = 2'd0;
      default:        wen_size = 2'd2;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cpu_en)      state_nxt = REQ;
      REQ:     if (bus_addr_ok) state_nxt = RESP;
      RESP:    if (bus_data_ok) state_nxt = DONE;
      DONE:                     state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  assign bus_req   = (state == REQ);
  assign cpu_stall = issue || (state == REQ) || (state == RESP);

  // Request fields load only on issue, so they hold through REQ/RESP/DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_wr    <= 1'b0;
      bus_size  <= 2'd0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      cpu_rdata <= '0;
    end else begin
      if (issue) begin
        bus_wr    <= wen_wr;
        bus_size  <= wen_size;
        bus_addr  <= cpu_addr;
        bus_wdata <= cpu_wdata;
      end
      if ((state == RESP) && bus_data_ok && !bus_wr)
        cpu_rdata <= bus_rdata;
    end
  end

endmodule
